// File: rtl/pulse_emitter_pkg.sv
// Shared definitions for the pulse emitter and its sibling edge detector:
// FSM state encoding, the default 2.6 ms cycle constant and a small helper.
package pulse_emitter_pkg;

  // FSM state encoding shared by the pulse emitter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // 2.6 ms at 50 MHz; also the edge detector's default filter time.
  localparam int DEFAULT_2P6MS_CYCLES = 130000;

  // Larger of two integers, used to size the shared cycle counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_emitter_sat_updown_counter.sv
// Saturating up/down counter holding the number of queued events.
// sat_hit flags an increment that had to be dropped because the count is full.
module sat_updown_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         sat_hit
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] value_reg;

  assign value   = value_reg;
  assign sat_hit = inc && !dec && (value_reg == MAX_VAL);

  // Count up/down; simultaneous inc and dec cancel, full count holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_reg <= '0;
    end else if (inc && !dec) begin
      if (value_reg != MAX_VAL) begin
        value_reg <= value_reg + 1'b1;
      end
    end else if (dec && !inc) begin
      if (value_reg != '0) begin
        value_reg <= value_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_emitter.sv
// Stretches single-cycle event pulses into fixed-width output pulses with a
// guaranteed low gap; events arriving mid-pulse are queued and replayed.
module pulse_emitter
  import pulse_emitter_pkg::*;
#(
  parameter int HIGH_CYCLES = DEFAULT_2P6MS_CYCLES,
  parameter int LOW_CYCLES  = DEFAULT_2P6MS_CYCLES,
  parameter int PEND_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger,
  output logic              dout,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  // One counter is shared by the HIGH and LOW phases; keep at least one bit.
  localparam int CNT_MAX = max_int(HIGH_CYCLES, LOW_CYCLES);
  localparam int CW      = max_int(1, $clog2(CNT_MAX));

  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES - 1);

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic              dout_reg;
  logic              busy_reg;
  logic              overflow_reg;

  logic              launch;
  logic              pend_nonzero;
  logic              pend_inc;
  logic              pend_dec;
  logic              sat_hit;
  logic [PEND_W-1:0] pend_value;

  // Launch edge is the last cycle of the low gap; pending accounting hinges on it.
  always_comb begin
    launch       = (state_reg == ST_LOW) && (cnt_reg == LOW_LAST);
    pend_nonzero = (pend_value != '0);
    pend_inc     = trigger && (state_reg != ST_IDLE) && !(launch && !pend_nonzero);
    pend_dec     = launch && pend_nonzero;
  end

  sat_updown_counter #(
    .W(PEND_W)
  ) u_pending (
    .clock   (clock),
    .reset   (reset),
    .inc     (pend_inc),
    .dec     (pend_dec),
    .value   (pend_value),
    .sat_hit (sat_hit)
  );

  // Pulse FSM with registered dout/busy and the shared phase counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      dout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (trigger) begin
            state_reg <= ST_HIGH;
            cnt_reg   <= '0;
            dout_reg  <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_reg == HIGH_LAST) begin
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
            dout_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_LOW: begin
          if (launch) begin
            cnt_reg <= '0;
            if (pend_nonzero || trigger) begin
              state_reg <= ST_HIGH;
              dout_reg  <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          dout_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky record of any event dropped because the queue was full.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (sat_hit) begin
      overflow_reg <= 1'b1;
    end
  end

  assign dout     = dout_reg;
  assign busy     = busy_reg;
  assign pending  = pend_value;
  assign overflow = overflow_reg;

endmodule
